// File: rtl/fifo_handshake_rx.sv
// Router input-port receiver: accepts one flit per RTS/CTS handshake into a small FIFO
// and presents the head entry first-word-fall-through to the output arbiters.
//
// state | meaning
// IDLE  | CTS low; waiting for DRTS, writes on DRTS when not full
// ACK   | CTS high for one cycle acknowledging the flit just written
module fifo_handshake_rx #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 4,
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  DRTS,
  output logic                  CTS,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
  output logic                  full,
  output logic [PTR_W:0]        occupancy
);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t                r_state;
  logic [PTR_W:0]        r_wr_ptr;
  logic [PTR_W:0]        r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_write;
  logic w_pop;

  assign w_empty = (r_rd_ptr == r_wr_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

  // Write eligibility looks only at the pre-edge full flag, so a same-cycle pop never frees a slot early.
  assign w_write = (r_state == IDLE) && DRTS && !w_full;
  assign w_pop   = (read_en_N | read_en_E | read_en_W | read_en_S | read_en_L) && !w_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_write) r_state <= ACK;
        ACK:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr[PTR_W-1:0]] <= RX;
  end

  assign CTS       = (r_state == ACK);
  assign Data_out  = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign empty     = w_empty;
  assign full      = w_full;
  assign occupancy = r_wr_ptr - r_rd_ptr;

endmodule

// File: tb/tb_fifo_handshake_rx.sv
// Directed bench for fifo_handshake_rx: reset, handshake, backpressure, wrap,
// simultaneous write/pop and asynchronous reset during ACK.
module tb_fifo_handshake_rx;

  logic        clk;
  logic        rst;
  logic [31:0] RX;
  logic        DRTS;
  logic        CTS;
  logic        read_en_N, read_en_E, read_en_W, read_en_S, read_en_L;
  logic [31:0] Data_out;
  logic        empty;
  logic        full;
  logic [2:0]  occupancy;

  int n_total;
  int n_pass;

  fifo_handshake_rx #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .DRTS      (DRTS),
    .CTS       (CTS),
    .read_en_N (read_en_N),
    .read_en_E (read_en_E),
    .read_en_W (read_en_W),
    .read_en_S (read_en_S),
    .read_en_L (read_en_L),
    .Data_out  (Data_out),
    .empty     (empty),
    .full      (full),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Full handshake: write edge then the ACK-ending edge; DRTS dropped afterwards.
  task automatic handshake(input logic [31:0] v);
    DRTS = 1'b1;
    RX   = v;
    tick();
    chk("hs_cts_high", {31'd0, CTS}, 32'd1);
    tick();
    DRTS = 1'b0;
  endtask

  task automatic pop_e();
    read_en_E = 1'b1;
    tick();
    read_en_E = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b0; RX = 32'hA5A5_0001; DRTS = 1'b1;
    read_en_N = 0; read_en_E = 0; read_en_W = 0; read_en_S = 0; read_en_L = 0;

    // T1: reset held with DRTS asserted
    tick(); tick(); tick();
    chk("rst_cts",   {31'd0, CTS},   32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full",  {31'd0, full},  32'd0);
    chk("rst_occ",   {29'd0, occupancy}, 32'd0);
    rst = 1'b1;

    // T2: first edge after release writes and raises CTS
    tick();
    chk("t2_cts",   {31'd0, CTS},   32'd1);
    chk("t2_data",  Data_out,       32'hA5A5_0001);
    chk("t2_empty", {31'd0, empty}, 32'd0);
    chk("t2_occ",   {29'd0, occupancy}, 32'd1);
    tick();
    chk("t2_cts_one_cycle", {31'd0, CTS}, 32'd0);
    chk("t2_no_ack_write",  {29'd0, occupancy}, 32'd1);
    DRTS = 1'b0;
    tick();
    chk("t2_idle_cts", {31'd0, CTS}, 32'd0);
    read_en_W = 1'b1;
    tick();
    read_en_W = 1'b0;
    chk("t2_pop_empty", {31'd0, empty}, 32'd1);
    chk("t2_pop_occ",   {29'd0, occupancy}, 32'd0);

    // T3: fill and backpressure
    for (int i = 1; i <= 4; i++) handshake(i);
    chk("t3_full", {31'd0, full}, 32'd1);
    chk("t3_occ",  {29'd0, occupancy}, 32'd4);
    chk("t3_head", Data_out, 32'd1);
    DRTS = 1'b1; RX = 32'd5;
    tick();
    chk("t3_bp_cts0", {31'd0, CTS}, 32'd0);
    tick();
    chk("t3_bp_cts1", {31'd0, CTS}, 32'd0);
    chk("t3_bp_occ",  {29'd0, occupancy}, 32'd4);
    read_en_E = 1'b1;
    tick();
    read_en_E = 1'b0;
    chk("t3_pop_no_write_cts", {31'd0, CTS}, 32'd0);
    chk("t3_pop_occ", {29'd0, occupancy}, 32'd3);
    chk("t3_head2",   Data_out, 32'd2);
    tick();
    chk("t3_retry_cts", {31'd0, CTS}, 32'd1);
    chk("t3_retry_occ", {29'd0, occupancy}, 32'd4);
    tick();
    DRTS = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      chk("t3_drain", Data_out, i);
      pop_e();
    end
    chk("t3_drained_empty", {31'd0, empty}, 32'd1);

    // T4: wrap the pointers with write/pop pairs
    for (int i = 0; i < 10; i++) begin
      handshake(32'h100 + i);
      chk("t4_data", Data_out, 32'h100 + i);
      chk("t4_occ",  {29'd0, occupancy}, 32'd1);
      chk("t4_not_both", {31'd0, empty & full}, 32'd0);
      pop_e();
      chk("t4_empty", {31'd0, empty}, 32'd1);
    end

    // T5: simultaneous write and pop
    handshake(32'h200);
    handshake(32'h201);
    chk("t5_occ2", {29'd0, occupancy}, 32'd2);
    DRTS = 1'b1; RX = 32'h202; read_en_L = 1'b1;
    tick();
    read_en_L = 1'b0;
    chk("t5_sim_cts",  {31'd0, CTS}, 32'd1);
    chk("t5_sim_occ",  {29'd0, occupancy}, 32'd2);
    chk("t5_sim_head", Data_out, 32'h201);
    tick();
    DRTS = 1'b0;
    read_en_N = 1; read_en_E = 1; read_en_W = 1; read_en_S = 1; read_en_L = 1;
    tick();
    read_en_N = 0; read_en_E = 0; read_en_W = 0; read_en_S = 0; read_en_L = 0;
    chk("t5_multi_single_pop", {29'd0, occupancy}, 32'd1);
    chk("t5_head3", Data_out, 32'h202);
    pop_e();
    chk("t5_empty", {31'd0, empty}, 32'd1);
    read_en_N = 1'b1; read_en_S = 1'b1;
    tick();
    read_en_N = 1'b0; read_en_S = 1'b0;
    chk("t5_empty_pop_empty", {31'd0, empty}, 32'd1);
    chk("t5_empty_pop_occ",   {29'd0, occupancy}, 32'd0);
    handshake(32'h203);
    chk("t5_after_empty_pop", Data_out, 32'h203);
    pop_e();

    // T6: async reset during ACK
    DRTS = 1'b1; RX = 32'h300;
    tick();
    chk("t6_ack", {31'd0, CTS}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_cts_drop", {31'd0, CTS},   32'd0);
    chk("t6_empty",    {31'd0, empty}, 32'd1);
    chk("t6_occ",      {29'd0, occupancy}, 32'd0);
    DRTS = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("t6_post_cts",   {31'd0, CTS},   32'd0);
    chk("t6_post_empty", {31'd0, empty}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
